// File: rtl/ahb5_ram_excl_multi.sv
// AHB5 zero-wait RAM slave with per-master exclusive-access monitors and write forwarding.
// Optional macro AHB5RAM_UNALIGNED_ERR_EN enables a two-cycle ERROR response to unaligned transfers.
module ahb5_ram_excl_multi #(
    parameter int unsigned AWIDTH    = 14,
    parameter int unsigned NMON      = 4,
    parameter int unsigned GRAN_LOG2 = 4
) (
    input  logic              HCLK,
    input  logic              HRESETn,
    input  logic              HSEL,
    input  logic              HREADY,
    input  logic [1:0]        HTRANS,
    input  logic [2:0]        HSIZE,
    input  logic              HWRITE,
    input  logic [3:0]        HMASTER,
    input  logic              HEXCL,
    input  logic [AWIDTH-1:0] HADDR,
    input  logic [31:0]       HWDATA,
    output logic              HREADYOUT,
    output logic              HRESP,
    output logic [31:0]       HRDATA,
    output logic              HEXOKAY
);

    localparam int unsigned WAW   = AWIDTH - 2;
    localparam int unsigned DEPTH = 2 ** WAW;
    localparam int unsigned TW    = AWIDTH - GRAN_LOG2;

    logic [31:0]     mem [DEPTH];

    logic [3:0]      wstrb_q;
    logic [WAW-1:0]  waddr_q;
    logic [31:0]     rdata_q;
    logic            exokay_q;
    logic [NMON-1:0] mon_valid_q, mon_valid_d;
    logic [TW-1:0]   mon_tag_q [NMON];
    logic [TW-1:0]   mon_tag_d [NMON];

    logic            accept_c, unaligned_c, xfer_c, commit_c;
    logic            master_ok_c, own_valid_c, excl_pass_c, fwd_hit_c;
    logic [3:0]      lane_c;
    logic [TW-1:0]   addr_tag_c, own_tag_c;
    logic [WAW-1:0]  word_addr_c;
    logic [31:0]     rd_word_c, rd_merge_c;
    logic            unused_c;

    assign unused_c    = HTRANS[0];
    assign accept_c    = HSEL & HREADY & HTRANS[1];
    assign xfer_c      = accept_c & ~unaligned_c;
    assign addr_tag_c  = HADDR[AWIDTH-1:GRAN_LOG2];
    assign word_addr_c = HADDR[AWIDTH-1:2];
    assign master_ok_c = ({28'd0, HMASTER} < 32'(NMON));
    assign excl_pass_c = master_ok_c & own_valid_c & (own_tag_c == addr_tag_c);
    assign commit_c    = xfer_c & HWRITE & (~HEXCL | excl_pass_c);

    // Byte lanes from size and low address bits
    always_comb begin
        lane_c = 4'b1111;
        case (HSIZE)
            3'd0:    lane_c = 4'b0001 << HADDR[1:0];
            3'd1:    lane_c = HADDR[1] ? 4'b1100 : 4'b0011;
            default: lane_c = 4'b1111;
        endcase
    end

    // Issuing master's own reservation
    always_comb begin
        own_valid_c = 1'b0;
        own_tag_c   = '0;
        for (int unsigned i = 0; i < NMON; i++) begin
            if (4'(i) == HMASTER) begin
                own_valid_c = mon_valid_q[i];
                own_tag_c   = mon_tag_q[i];
            end
        end
    end

    // Monitor update; the issuing master's set is applied last so it wins
    always_comb begin
        mon_valid_d = mon_valid_q;
        for (int unsigned i = 0; i < NMON; i++) begin
            mon_tag_d[i] = mon_tag_q[i];
            if (commit_c && (4'(i) != HMASTER) && (mon_tag_q[i] == addr_tag_c))
                mon_valid_d[i] = 1'b0;
            if (xfer_c && HEXCL && (4'(i) == HMASTER)) begin
                if (HWRITE) begin
                    mon_valid_d[i] = 1'b0;
                end else begin
                    mon_valid_d[i] = 1'b1;
                    mon_tag_d[i]   = addr_tag_c;
                end
            end
        end
    end

    // Read path merges the write committing this cycle into the returned word
    always_comb begin
        rd_word_c  = mem[word_addr_c];
        fwd_hit_c  = (waddr_q == word_addr_c);
        rd_merge_c = rd_word_c;
        for (int unsigned b = 0; b < 4; b++) begin
            if (fwd_hit_c && wstrb_q[b])
                rd_merge_c[8*b +: 8] = HWDATA[8*b +: 8];
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            wstrb_q     <= 4'b0000;
            waddr_q     <= '0;
            rdata_q     <= 32'd0;
            exokay_q    <= 1'b0;
            mon_valid_q <= '0;
            for (int unsigned i = 0; i < NMON; i++)
                mon_tag_q[i] <= '0;
        end else begin
            mon_valid_q <= mon_valid_d;
            for (int unsigned i = 0; i < NMON; i++)
                mon_tag_q[i] <= mon_tag_d[i];
            if (HREADY) begin
                wstrb_q  <= commit_c ? lane_c : 4'b0000;
                waddr_q  <= word_addr_c;
                exokay_q <= xfer_c & HEXCL & (HWRITE ? excl_pass_c : master_ok_c);
                if (xfer_c && !HWRITE)
                    rdata_q <= rd_merge_c;
            end
        end
    end

    // Storage is never reset; a reset clears wstrb_q and so abandons a pending write
    always_ff @(posedge HCLK) begin
        for (int unsigned b = 0; b < 4; b++) begin
            if (HREADY && wstrb_q[b])
                mem[waddr_q][8*b +: 8] <= HWDATA[8*b +: 8];
        end
    end

    assign HRDATA  = rdata_q;
    assign HEXOKAY = exokay_q;

`ifdef AHB5RAM_UNALIGNED_ERR_EN
    typedef enum logic [1:0] {ST_OKAY, ST_ERR1, ST_ERR2} state_t;

    state_t state_q, state_d;
    logic   hreadyout_q, hreadyout_d;
    logic   hresp_q, hresp_d;

    assign unaligned_c = ((HSIZE == 3'd1) & HADDR[0]) | ((HSIZE == 3'd2) & (|HADDR[1:0]));

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q     <= ST_OKAY;
            hreadyout_q <= 1'b1;
            hresp_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            hreadyout_q <= hreadyout_d;
            hresp_q     <= hresp_d;
        end
    end

    // ERR1 stalls the bus, ERR2 completes the error; ERR2 may accept a new transfer
    always_comb begin
        state_d     = state_q;
        hreadyout_d = 1'b1;
        hresp_d     = 1'b0;
        case (state_q)
            ST_OKAY: if (accept_c && unaligned_c) state_d = ST_ERR1;
            ST_ERR1: state_d = ST_ERR2;
            ST_ERR2: state_d = (accept_c && unaligned_c) ? ST_ERR1 : ST_OKAY;
            default: state_d = ST_OKAY;
        endcase
        hreadyout_d = (state_d != ST_ERR1);
        hresp_d     = (state_d != ST_OKAY);
    end

    assign HREADYOUT = hreadyout_q;
    assign HRESP     = hresp_q;
`else
    assign unaligned_c = 1'b0;
    assign HREADYOUT   = 1'b1;
    assign HRESP       = 1'b0;
`endif

endmodule

// File: tb/tb_ahb5_ram_excl_multi.sv
// Scoreboard bench for ahb5_ram_excl_multi: driver feeds a byte-level reference model,
// monitor compares each completed data phase against the queued expectation.
module tb_ahb5_ram_excl_multi;

    localparam int unsigned AW = 14;
    localparam int unsigned NM = 2;
    localparam int unsigned GL = 4;

    logic          HCLK = 1'b0;
    logic          HRESETn = 1'b1;
    logic          HSEL = 1'b0;
    logic [1:0]    HTRANS = 2'b00;
    logic [2:0]    HSIZE = 3'd0;
    logic          HWRITE = 1'b0;
    logic [3:0]    HMASTER = 4'd0;
    logic          HEXCL = 1'b0;
    logic [AW-1:0] HADDR = '0;
    logic [31:0]   HWDATA = 32'd0;
    logic          HREADYOUT, HRESP, HEXOKAY;
    logic [31:0]   HRDATA;
    wire           HREADY = HREADYOUT;

    ahb5_ram_excl_multi #(.AWIDTH(AW), .NMON(NM), .GRAN_LOG2(GL)) dut (
        .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(HSEL), .HREADY(HREADY),
        .HTRANS(HTRANS), .HSIZE(HSIZE), .HWRITE(HWRITE), .HMASTER(HMASTER),
        .HEXCL(HEXCL), .HADDR(HADDR), .HWDATA(HWDATA),
        .HREADYOUT(HREADYOUT), .HRESP(HRESP), .HRDATA(HRDATA), .HEXOKAY(HEXOKAY)
    );

    always #5 HCLK = ~HCLK;

    typedef struct {
        bit          sel;
        bit [1:0]    trans;
        bit          write;
        bit [2:0]    size;
        bit [3:0]    master;
        bit          excl;
        bit [AW-1:0] addr;
        bit [31:0]   wdata;
    } xfer_t;

    typedef struct {
        bit        is_read;
        bit        chk_data;
        bit [31:0] rdata;
        bit        exokay;
        bit        err;
        int        id;
    } exp_t;

    int   checks = 0;
    int   errors = 0;
    int   nid = 0;
    exp_t q[$];
    logic acc_next = 1'b0;
    logic dp_active = 1'b0;
    bit   err_seen = 1'b0;
    logic [31:0] last_wdata = 32'd0;

    // Reference model: byte memory plus one reservation (granule index) per master
    bit [7:0] mem_m   [2**AW];
    bit       known_m [2**AW];
    bit       res_v   [NM];
    int       res_g   [NM];
    int       last_ld [4];

    task automatic check(input string nm, input int id, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s #%0d actual=%h expected=%h", nm, id, act, exp);
        end
    endtask

    function automatic bit is_unaligned(input xfer_t t);
`ifdef AHB5RAM_UNALIGNED_ERR_EN
        return (t.size == 3'd1 && t.addr[0]) || (t.size == 3'd2 && t.addr[1:0] != 2'b00);
`else
        return 1'b0;
`endif
    endfunction

    function automatic exp_t model(input xfer_t t);
        exp_t e;
        int a, m, g, base, n, w;
        bit has, pass;
        e = '{default: 0};
        if (is_unaligned(t)) begin
            e.err = 1'b1;
            return e;
        end
        a = int'(t.addr);
        m = int'(t.master);
        g = a >> GL;
        has = (m < NM);
        case (t.size)
            3'd0:    begin base = a;            n = 1; end
            3'd1:    begin base = a & ~1;       n = 2; end
            default: begin base = a & ~3;       n = 4; end
        endcase
        if (!t.write) begin
            w = a & ~3;
            e.is_read  = 1'b1;
            e.chk_data = 1'b1;
            for (int k = 0; k < 4; k++) begin
                if (!known_m[w+k]) e.chk_data = 1'b0;
                e.rdata[8*k +: 8] = mem_m[w+k];
            end
            e.exokay = t.excl && has;
            if (t.excl && has) begin
                res_v[m] = 1'b1;
                res_g[m] = g;
            end
        end else begin
            pass = !t.excl || (has && res_v[m] && res_g[m] == g);
            if (t.excl && has) res_v[m] = 1'b0;
            e.exokay = t.excl && pass;
            if (pass) begin
                for (int k = 0; k < n; k++) begin
                    mem_m[base+k]   = t.wdata[8*((base+k)%4) +: 8];
                    known_m[base+k] = 1'b1;
                end
                for (int j = 0; j < NM; j++)
                    if (j != m && res_v[j] && res_g[j] == g) res_v[j] = 1'b0;
            end
        end
        return e;
    endfunction

    function automatic xfer_t mk(input bit w, input int sz, input int m, input bit ex, input int a, input bit [31:0] d);
        xfer_t t;
        t.sel = 1'b1; t.trans = 2'b10; t.write = w; t.size = 3'(sz);
        t.master = 4'(m); t.excl = ex; t.addr = AW'(a); t.wdata = d;
        return t;
    endfunction

    function automatic xfer_t idle_x();
        xfer_t t;
        t = mk(1'b0, 0, 0, 1'b0, 0, 32'd0);
        t.sel = 1'b0;
        t.trans = 2'b00;
        return t;
    endfunction

    // Called at a negedge; holds the address phase while HREADYOUT is low
    task automatic drive(input xfer_t t, input bit track);
        int guard = 0;
        exp_t e;
        HSEL = t.sel; HTRANS = t.trans; HWRITE = t.write; HSIZE = t.size;
        HMASTER = t.master; HEXCL = t.excl; HADDR = t.addr; HWDATA = last_wdata;
        while (HREADYOUT !== 1'b1 && guard < 16) begin
            @(negedge HCLK);
            guard++;
        end
        if (guard >= 16) check("hready_timeout", nid, 32'(HREADYOUT), 32'd1);
        if (t.sel && t.trans[1]) begin
            if (track) begin
                e = model(t);
                e.id = nid++;
                q.push_back(e);
                acc_next = 1'b1;
            end else begin
                acc_next = 1'b0;
            end
            last_wdata = t.wdata;
        end else begin
            acc_next = 1'b0;
        end
        @(negedge HCLK);
    endtask

    always @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn)       dp_active <= 1'b0;
        else if (HREADYOUT) dp_active <= acc_next;
    end

    // Monitor: one comparison set per observed data-phase cycle
    always @(negedge HCLK) begin
        exp_t e;
        if (dp_active) begin
            if (q.size() == 0) begin
                check("queue_underflow", -1, 32'd1, 32'd0);
            end else begin
                e = q[0];
                if (e.err && !err_seen) begin
                    check("err1_ready", e.id, 32'(HREADYOUT), 32'd0);
                    check("err1_resp", e.id, 32'(HRESP), 32'd1);
                    err_seen = 1'b1;
                end else begin
                    check("ready", e.id, 32'(HREADYOUT), 32'd1);
                    check("resp", e.id, 32'(HRESP), 32'(e.err));
                    check("exokay", e.id, 32'(HEXOKAY), 32'(e.exokay));
                    if (e.is_read && e.chk_data) check("rdata", e.id, HRDATA, e.rdata);
                    void'(q.pop_front());
                    err_seen = 1'b0;
                end
            end
        end
    end

    initial begin
        xfer_t t;
        int sz, a, m;
        for (int i = 0; i < NM; i++) begin res_v[i] = 1'b0; res_g[i] = 0; end
        for (int i = 0; i < 4; i++) last_ld[i] = 'h600;

        #1 HRESETn = 1'b0;
        repeat (3) @(negedge HCLK);
        HRESETn = 1'b1;
        check("rst_hreadyout", 0, 32'(HREADYOUT), 32'd1);
        check("rst_hresp", 0, 32'(HRESP), 32'd0);
        check("rst_hexokay", 0, 32'(HEXOKAY), 32'd0);

        // Word write/read, then byte merge
        drive(mk(1, 2, 0, 0, 'h100, 32'hDEADBEEF), 1);
        drive(idle_x(), 1);
        drive(mk(0, 2, 0, 0, 'h100, 0), 1);
        drive(mk(1, 0, 0, 0, 'h102, 32'h0055_0000), 1);
        drive(idle_x(), 1);
        drive(mk(0, 2, 0, 0, 'h100, 0), 1);
        // Write immediately followed by read of the same word
        drive(mk(1, 2, 0, 0, 'h200, 32'h12345678), 1);
        drive(mk(0, 2, 0, 0, 'h200, 0), 1);
        drive(mk(1, 1, 0, 0, 'h202, 32'hABCD_0000), 1);
        drive(mk(0, 2, 0, 0, 'h200, 0), 1);
        // LDREX/STREX pass, then repeated STREX fails
        drive(mk(1, 2, 0, 0, 'h300, 32'h0), 1);
        drive(mk(0, 2, 1, 1, 'h300, 0), 1);
        drive(mk(1, 2, 1, 1, 'h300, 32'hA5), 1);
        drive(mk(0, 2, 1, 0, 'h300, 0), 1);
        drive(mk(1, 2, 1, 1, 'h300, 32'h77), 1);
        drive(mk(0, 2, 1, 0, 'h300, 0), 1);
        // Other master's write to the granule kills the reservation
        drive(mk(0, 2, 1, 1, 'h300, 0), 1);
        drive(mk(1, 2, 0, 0, 'h308, 32'h11), 1);
        drive(mk(1, 2, 1, 1, 'h300, 32'h22), 1);
        drive(mk(0, 2, 1, 0, 'h300, 0), 1);
        // Master beyond NMON, and two concurrent reservations
        drive(mk(1, 2, 0, 0, 'h400, 32'h4444_4444), 1);
        drive(mk(0, 2, 3, 1, 'h400, 0), 1);
        drive(mk(1, 2, 3, 1, 'h400, 32'h3333_3333), 1);
        drive(mk(0, 2, 0, 0, 'h400, 0), 1);
        drive(mk(0, 2, 0, 1, 'h410, 0), 1);
        drive(mk(0, 2, 1, 1, 'h420, 0), 1);
        drive(mk(1, 2, 0, 1, 'h410, 32'h0000_0A10), 1);
        drive(mk(1, 2, 1, 1, 'h420, 32'h0000_0B20), 1);
        drive(mk(0, 2, 0, 0, 'h410, 0), 1);
        drive(mk(0, 2, 0, 0, 'h420, 0), 1);
        // Unaligned accesses
        drive(mk(1, 2, 0, 0, 'h500, 32'h0), 1);
        drive(mk(1, 2, 0, 0, 'h501, 32'hFFFF_FFFF), 1);
        drive(mk(0, 2, 0, 0, 'h500, 0), 1);
        drive(mk(1, 1, 0, 0, 'h503, 32'h5A5A_5A5A), 1);
        drive(mk(0, 2, 0, 0, 'h500, 0), 1);
        drive(idle_x(), 1);
        drive(idle_x(), 1);

        // Reset during a write's data phase abandons the write
        drive(mk(1, 2, 0, 0, 'h100, 32'hCAFEF00D), 0);
        HSEL = 1'b0; HTRANS = 2'b00; HWDATA = last_wdata;
        HRESETn = 1'b0;
        @(negedge HCLK);
        HRESETn = 1'b1;
        for (int i = 0; i < NM; i++) res_v[i] = 1'b0;
        check("rst2_hreadyout", 1, 32'(HREADYOUT), 32'd1);
        check("rst2_hresp", 1, 32'(HRESP), 32'd0);
        check("rst2_hexokay", 1, 32'(HEXOKAY), 32'd0);
        drive(mk(0, 2, 0, 0, 'h100, 0), 1);

        // Prefill the random window so every read has known data
        for (int i = 0; i < 64; i++) drive(mk(1, 2, i % 4, 0, 'h600 + 4*i, $urandom), 1);

        for (int n = 0; n < 1500; n++) begin
            int r;
            r = $urandom_range(0, 99);
            if (r < 8) begin
                drive(idle_x(), 1);
            end else if (r < 11) begin
                t = idle_x(); t.sel = 1'b1; t.trans = 2'b01;
                drive(t, 1);
            end else begin
                sz = $urandom_range(0, 2);
                m  = $urandom_range(0, 3);
                a  = 'h600 + $urandom_range(0, 255);
`ifdef AHB5RAM_UNALIGNED_ERR_EN
                if ($urandom_range(0, 9) != 0) a = a & ~((1 << sz) - 1);
`endif
                t = mk(1'($urandom_range(0, 1)), sz, m, ($urandom_range(0, 9) < 3), a, $urandom);
                if (t.excl && t.write && $urandom_range(0, 1) == 1) t.addr = AW'(last_ld[m]);
                if (t.excl && !t.write) last_ld[m] = int'(t.addr);
                if (r < 14) t.sel = 1'b0;
                drive(t, 1);
            end
        end

        repeat (4) drive(idle_x(), 1);
        check("queue_drained", 0, 32'(q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
